data_mem_ws: RTL and testbench

//  Parametrised data memory for the ARM datapath: byte/halfword/word load-store,

---
 rtl/data_mem_ws.sv | 110 +++++++++++
 tb/tb_data_mem_ws.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ws.sv
// data_mem_ws: byte/half/word data memory with sign/zero-extended loads, wait states and a req/ready handshake.
module data_mem_ws #(
  parameter int    DEPTH_WORDS = 64,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        fault,
  output logic        busy
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, sext_q, sext_d, ready_q, ready_d, fault_q, fault_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] a_q, a_d, wd_q, wd_d, rd_q, rd_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] wrd, wnew, ld;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        bad;
  assign idx    = a_q[AW+1:2];
  assign wrd    = mem[idx];
  assign lane_b = wrd[8*a_q[1:0] +: 8];
  assign lane_h = wrd[16*a_q[1] +: 16];
  assign bad    = (size_q == 2'b11) || (size_q == 2'b01 && a_q[0]) ||
                  (size_q == 2'b10 && a_q[1:0] != 2'b00) || (a_q[31:2] >= 30'(DEPTH_WORDS));
  assign ld     = size_q == 2'b00 ? {{24{sext_q & lane_b[7]}}, lane_b} :
                  size_q == 2'b01 ? {{16{sext_q & lane_h[15]}}, lane_h} : wrd;
  always_comb begin
    wnew = wrd;
    if (size_q == 2'b00) wnew[8*a_q[1:0] +: 8] = wd_q[7:0];
    if (size_q == 2'b01) wnew[16*a_q[1] +: 16] = wd_q[15:0];
    if (size_q == 2'b10) wnew = wd_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    if (state_q == IDLE) begin
      if (req) begin
        we_d    = WE;
        size_d  = Size;
        sext_d  = SignExt;
        a_d     = A;
        wd_d    = WD;
        cnt_d   = 4'(WAIT_STATES);
        state_d = WAIT_STATES > 0 ? WAIT : ACCESS;
      end
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
    end else begin
      state_d = IDLE;
      ready_d = 1'b1;
      fault_d = bad;
      rd_d    = (bad || we_q) ? 32'd0 : ld;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && we_q && !bad) mem[idx] <= wnew;
  end
  assign ReadData = rd_q;
  assign ready    = ready_q;
  assign fault    = fault_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: randomized and directed checks of data_mem_ws against a byte-array reference model.
module tb_data_mem_ws;
  logic        clk = 1'b0;
  logic        reset;
  logic        req[2], we[2], se[2], ready[2], fault[2], busy[2];
  logic [1:0]  sz[2];
  logic [31:0] a[2], wd[2], rd[2];
  logic [7:0]  bm[2][256];
  int          ws[2] = '{0, 3};
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_mem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .WE(we[0]), .Size(sz[0]), .SignExt(se[0]),
    .A(a[0]), .WD(wd[0]), .ReadData(rd[0]), .ready(ready[0]), .fault(fault[0]), .busy(busy[0]));
  data_mem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .req(req[1]), .WE(we[1]), .Size(sz[1]), .SignExt(se[1]),
    .A(a[1]), .WD(wd[1]), .ReadData(rd[1]), .ready(ready[1]), .fault(fault[1]), .busy(busy[1]));
  typedef struct packed {
    logic w; logic [1:0] s; logic e; logic [31:0] ad, dat, ex; logic ef, ck;
  } op_t;
  op_t dir[18] = '{
    '{1'b1, 2'd2, 1'b0, 32'd0,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0},
    '{1'b0, 2'd2, 1'b0, 32'd0,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1},
    '{1'b1, 2'd2, 1'b0, 32'd4,   32'hCAFEBABE, 32'h0,        1'b0, 1'b0},
    '{1'b1, 2'd0, 1'b0, 32'd5,   32'h000000AB, 32'h0,        1'b0, 1'b0},
    '{1'b0, 2'd2, 1'b0, 32'd4,   32'h0,        32'hCAFEABBE, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 32'd5,   32'h0,        32'hFFFFFFAB, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b0, 32'd5,   32'h0,        32'h000000AB, 1'b0, 1'b1},
    '{1'b1, 2'd1, 1'b0, 32'd6,   32'h00008001, 32'h0,        1'b0, 1'b0},
    '{1'b0, 2'd2, 1'b0, 32'd4,   32'h0,        32'h8001ABBE, 1'b0, 1'b1},
    '{1'b0, 2'd1, 1'b1, 32'd6,   32'h0,        32'hFFFF8001, 1'b0, 1'b1},
    '{1'b0, 2'd1, 1'b0, 32'd6,   32'h0,        32'h00008001, 1'b0, 1'b1},
    '{1'b0, 2'd2, 1'b0, 32'd2,   32'h0,        32'h0,        1'b1, 1'b1},
    '{1'b0, 2'd1, 1'b0, 32'd1,   32'h0,        32'h0,        1'b1, 1'b1},
    '{1'b0, 2'd3, 1'b0, 32'd0,   32'h0,        32'h0,        1'b1, 1'b1},
    '{1'b0, 2'd2, 1'b0, 32'd256, 32'h0,        32'h0,        1'b1, 1'b1},
    '{1'b1, 2'd2, 1'b0, 32'd2,   32'h55555555, 32'h0,        1'b1, 1'b0},
    '{1'b1, 2'd3, 1'b0, 32'd0,   32'h11111111, 32'h0,        1'b1, 1'b0},
    '{1'b0, 2'd2, 1'b0, 32'd0,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1}
  };
  // Reference: memory as a little-endian byte array, sizes as byte counts.
  function automatic void mdl(input int d, input logic w, input logic [1:0] s, input logic e,
                              input logic [31:0] ad, input logic [31:0] dat,
                              output logic [31:0] r, output logic f);
    int n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    r = 32'd0;
    f = (s == 2'd3) || (ad % n != 0) || (ad / 4 >= 64);
    if (!f)
      for (int i = 0; i < n; i++)
        if (w) bm[d][ad+i] = dat[8*i +: 8];
        else r = r | (32'(bm[d][ad+i]) << (8 * i));
    if (!f && !w && e && n < 4 && r[8*n-1]) r = r | (32'hFFFFFFFF << (8 * n));
  endfunction
  task automatic acc(input int d, input logic w, input logic [1:0] s, input logic e,
                     input logic [31:0] ad, input logic [31:0] dat,
                     output logic [31:0] r, output logic f, output int lat);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; sz[d] = s; se[d] = e; a[d] = ad; wd[d] = dat;
    @(negedge clk);
    req[d] = 1'b0;
    lat = 0;
    while (!ready[d] && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    r = rd[d];
    f = fault[d];
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready d=%0d got %b want 0", d, ready[d]); end
      n_chk++; if (fault[d] !== 1'b0) begin n_fail++; $display("FAIL reset_fault d=%0d got %b want 0", d, fault[d]); end
      n_chk++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d=%0d got %b want 0", d, busy[d]); end
      n_chk++; if (rd[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata d=%0d got %h want 0", d, rd[d]); end
    end
    reset = 1'b0;
  endtask
  task automatic test_directed;
    logic [31:0] r;
    logic f;
    int l;
    for (int i = 0; i < 18; i++) begin
      acc(0, dir[i].w, dir[i].s, dir[i].e, dir[i].ad, dir[i].dat, r, f, l);
      n_chk++; if (l !== 1) begin n_fail++; $display("FAIL dir_latency op=%0d got %0d want 1", i, l); end
      n_chk++; if (f !== dir[i].ef) begin n_fail++; $display("FAIL dir_fault op=%0d got %b want %b", i, f, dir[i].ef); end
      if (dir[i].ck) begin
        n_chk++; if (r !== dir[i].ex) begin n_fail++; $display("FAIL dir_rdata op=%0d got %h want %h", i, r, dir[i].ex); end
      end
    end
  endtask
  task automatic test_random;
    logic [31:0] r, er, ad, dat;
    logic f, ef, w, e;
    logic [1:0] s;
    int l;
    for (int i = 0; i < 64; i++) begin
      dat = $urandom;
      mdl(0, 1'b1, 2'd2, 1'b0, 32'(4 * i), dat, er, ef);
      acc(0, 1'b1, 2'd2, 1'b0, 32'(4 * i), dat, r, f, l);
    end
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      e = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      dat = $urandom;
      mdl(0, w, s, e, ad, dat, er, ef);
      acc(0, w, s, e, ad, dat, r, f, l);
      n_chk++; if (l !== 1) begin n_fail++; $display("FAIL rnd_latency i=%0d got %0d want 1", i, l); end
      n_chk++; if (f !== ef) begin n_fail++; $display("FAIL rnd_fault i=%0d a=%h s=%0d got %b want %b", i, ad, s, f, ef); end
      if (!w) begin
        n_chk++; if (r !== er) begin n_fail++; $display("FAIL rnd_rdata i=%0d a=%h s=%0d e=%b got %h want %h", i, ad, s, e, r, er); end
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] er, ad, dat;
    logic ef, e;
    logic [1:0] s;
    int k = 0, done = 0, acc_cyc = -1;
    for (int c = 0; c < 400 && done < 14; c++) begin
      @(negedge clk);
      if (acc_cyc >= 0 && c - acc_cyc >= 1 && c - acc_cyc <= 4) begin
        n_chk++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy cyc=%0d got %b want 1", c - acc_cyc, busy[1]); end
      end
      if (ready[1]) begin
        done++;
        n_chk++; if (c - acc_cyc !== 5) begin n_fail++; $display("FAIL b2b_latency op=%0d got %0d want 5", done, c - acc_cyc); end
        n_chk++; if (fault[1] !== ef) begin n_fail++; $display("FAIL b2b_fault op=%0d got %b want %b", done, fault[1], ef); end
        if (!we[1] || k > 6) begin
          n_chk++; if (k > 6 && rd[1] !== er) begin n_fail++; $display("FAIL b2b_rdata op=%0d got %h want %h", done, rd[1], er); end
        end
        acc_cyc = -1;
      end
      if (!busy[1] && k < 14) begin
        e = 1'($urandom_range(0, 1));
        if (k < 6) begin
          s = 2'd2; ad = 32'(32 + 4 * k); dat = $urandom;
        end else begin
          s = 2'($urandom_range(0, 2));
          ad = 32'(32 + 4 * $urandom_range(0, 5));
          ad = ad + (s == 2'd0 ? 32'($urandom_range(0, 3)) : s == 2'd1 ? 32'(2 * $urandom_range(0, 1)) : 32'd0);
          dat = $urandom;
        end
        req[1] = 1'b1; we[1] = (k < 6); sz[1] = s; se[1] = e; a[1] = ad; wd[1] = dat;
        mdl(1, k < 6, s, e, ad, dat, er, ef);
        acc_cyc = c;
        k++;
      end else if (busy[1]) begin
        we[1] = 1'($urandom_range(0, 1)); sz[1] = 2'($urandom_range(0, 3));
        a[1] = $urandom; wd[1] = $urandom;
      end else req[1] = 1'b0;
    end
    req[1] = 1'b0;
    n_chk++; if (done !== 14) begin n_fail++; $display("FAIL b2b_count got %0d want 14", done); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] r, er;
    logic f, ef;
    int l;
    mdl(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'h11111111, er, ef);
    acc(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'h11111111, r, f, l);
    n_chk++; if (l !== 4) begin n_fail++; $display("FAIL mid_first_latency got %0d want 4", l); end
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; se[1] = 1'b0; a[1] = 32'd8; wd[1] = 32'h12345678;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    n_chk++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy[1]); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy[1]); end
    n_chk++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", ready[1]); end
    n_chk++; if (fault[1] !== 1'b0) begin n_fail++; $display("FAIL mid_fault got %b want 0", fault[1]); end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    mdl(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, er, ef);
    acc(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, r, f, l);
    n_chk++; if (r !== er) begin n_fail++; $display("FAIL mid_old_value got %h want %h", r, er); end
    n_chk++; if (f !== 1'b0) begin n_fail++; $display("FAIL mid_load_fault got %b want 0", f); end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'd0; se[d] = 1'b0; a[d] = 32'd0; wd[d] = 32'd0;
    end
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
